alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
Issue-and-collect controller for the pipelined multiply/divide unit. It serves the ALU/microcode side and runs one MULU/MULS/DIVU/DIVS operation at a time. Per operation it:
- accepts a request and freezes the operands;
- waits out the unit's fixed pipeline latency;
- selects and packs the 68000-format result and computes N/Z/V/C;
- flags divide-by-zero (trap) and divide overflow.

Parameters:
MUL_LATENCY, 18, pipeline depth of the multiplier outputs, in clocks.
DIV_LATENCY, 30, pipeline depth of the divider outputs, in clocks.
CNT_W, 6, width of the latency counter; must satisfy 2^CNT_W > max latency.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request strobe, sampled only in IDLE
op  in  2  0=MULU 1=MULS 2=DIVU 3=DIVS
operand1  in  32  dividend (div) or multiplicand in [15:0] (mul)
operand2  in  32  divisor/multiplier in [15:0]
mdu_operand1  out  32  registered operand1 driven to the unit
mdu_operand2  out  32  registered operand2 driven to the unit
divu_quotient  in  32  unit output
divu_remainder  in  16  unit output
divs_quotient  in  32  unit output
divs_remainder  in  16  unit output
mulu_result  in  32  unit output
muls_result  in  32  unit output
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
result  out  32  value for the destination register, valid with done and held until the next done
flag_n, flag_z, flag_v, flag_c  out  1 each  condition codes, valid with done
div_by_zero  out  1  one-cycle trap pulse, coincident with done

Behaviour:
- Reset: all outputs are 0; the state is IDLE.
- Reset mid-operation returns to IDLE with no done; the next start works normally.
- States: IDLE, WAIT, FINISH.
- IDLE, start=1, op is a divide and operand2[15:0]==0 (divide-by-zero):
  - go to FINISH without counting;
  - next cycle: done=1, div_by_zero=1, result=operand1, all flags 0.
- IDLE, start=1, any other case:
  - latch op, operand1 and operand2 into mdu_operand1/2;
  - load the counter with MUL_LATENCY or DIV_LATENCY;
  - go to WAIT and raise busy.
- mdu_operand1/2 stay constant until the next accepted start, because the unit samples them every clock.
- WAIT: decrement the counter each clock; at counter==1, go to FINISH.
- FINISH: register result and flags, pulse done, return to IDLE. The next start may be sampled in this same cycle.
- Total latency, start-sampling edge to done-high cycle: L+2 clocks, where L is the op's latency.
- start while busy is ignored, with no queueing.
- op, operand1 and operand2 are don't-care except in the start cycle.
- MULU/MULS result: 32-bit product from the matching output.
  - N=result[31], Z=(result==0), V=0, C=0.
- DIVU/DIVS result: {remainder[15:0], quotient[15:0]} from the matching outputs.
  - N=quotient[15], Z=(quotient[15:0]==0), V=0, C=0.
  - DIVS remainder carries the sign of the dividend.
- DIVU overflow: divu_quotient[31:16] != 0.
- DIVS overflow: divs_quotient[31:15] is not all-equal. This covers 0x80000000 / -1.
- On overflow: V=1, N=0, Z=0, C=0, result=latched operand1 (destination unchanged), div_by_zero=0.

Decomposition:
- Shared package holds:
  - op encodings MULU/MULS/DIVU/DIVS;
  - state encodings;
  - default latency constants 18/30.
- One sub-module is natural: muldiv_result_pack. It is combinational and does result selection/packing, overflow detection and flag generation.
- The FSM and counter stay in the top.

Test Plan:
- MULU 0x0000FFFF × 0x0000FFFF → done at start+20; result 0xFFFE0001; N=1 Z=0 V=0 C=0; busy high 19 cycles.
- MULS 0xFFFF (−1) × 0x0002 → result 0xFFFFFFFE, N=1; then MULS 0 × 0x1234 → result 0, Z=1.
- DIVU 0x000186A0 / 7 → done at start+32; result 0x000537CD (rem 5, quot 14285); flags 0. DIVS 0xFFFFFFF9 / 2 → result 0xFFFFFFFD (rem −1, quot −3), N=1.
- Overflow:
  - DIVU 0x00100000 / 1 → V=1, result 0x00100000.
  - DIVS 0x80000000 / 0xFFFF → V=1, result 0x80000000.
  - DIVS 0x00010000 / 2 → quotient 0x8000 → V=1.
- DIVU or DIVS with operand2=0x00000000 → done and div_by_zero high one cycle after start; result=operand1; no WAIT; mdu_operand1/2 unchanged.
- Robustness:
  - start pulsed every cycle during a DIVU → exactly one done.
  - Back-to-back start in the FINISH cycle → accepted.
  - reset_n low at WAIT count 10 → no done; outputs 0; a fresh MULU completes correctly.

Source files
------------

// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide issue-and-collect sequencer.
package alu_muldiv_sequencer_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned HALF_W          = 16;
    localparam int unsigned OP_W            = 2;
    localparam int unsigned MUL_LATENCY_DEF = 18;
    localparam int unsigned DIV_LATENCY_DEF = 30;
    localparam int unsigned CNT_W_DEF       = 6;

    typedef enum logic [OP_W-1:0] {
        OP_MULU = 2'd0,
        OP_MULS = 2'd1,
        OP_DIVU = 2'd2,
        OP_DIVS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    // True for the two divide opcodes.
    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIVS);
    endfunction

endpackage

// File: rtl/muldiv_result_pack.sv
// Selects the unit output for the latched op, packs it into 68000 format and
// derives condition codes, including divide-overflow detection.
module muldiv_result_pack
    import alu_muldiv_sequencer_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] divu_quotient,
    input  logic [HALF_W-1:0] divu_remainder,
    input  logic [DATA_W-1:0] divs_quotient,
    input  logic [HALF_W-1:0] divs_remainder,
    input  logic [DATA_W-1:0] mulu_result,
    input  logic [DATA_W-1:0] muls_result,
    output logic [DATA_W-1:0] result_c,
    output flags_t            flags_c
);

    logic [HALF_W-1:0] quot;
    logic [HALF_W-1:0] rem;
    logic              ovf;

    // Result selection, packing and flag generation.
    always_comb begin
        result_c = '0;
        flags_c  = '0;
        quot     = '0;
        rem      = '0;
        ovf      = 1'b0;
        case (op)
            OP_MULU, OP_MULS: begin
                result_c  = (op == OP_MULU) ? mulu_result : muls_result;
                flags_c.n = result_c[DATA_W-1];
                flags_c.z = (result_c == '0);
            end
            default: begin
                if (op == OP_DIVU) begin
                    quot = divu_quotient[HALF_W-1:0];
                    rem  = divu_remainder;
                    ovf  = |divu_quotient[DATA_W-1:HALF_W];
                end else begin
                    // Signed quotient must fit in 16 bits: bits [31:15] all equal.
                    quot = divs_quotient[HALF_W-1:0];
                    rem  = divs_remainder;
                    ovf  = !((&divs_quotient[DATA_W-1:HALF_W-1]) ||
                             !(|divs_quotient[DATA_W-1:HALF_W-1]));
                end
                if (ovf) begin
                    // Destination register is left unchanged on overflow.
                    result_c  = operand1;
                    flags_c.v = 1'b1;
                end else begin
                    result_c  = {rem, quot};
                    flags_c.n = quot[HALF_W-1];
                    flags_c.z = (quot == '0);
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Issue-and-collect controller: one MULU/MULS/DIVU/DIVS at a time through the
// pipelined multiply/divide unit, with divide-by-zero trap and overflow flags.
module alu_muldiv_sequencer
    import alu_muldiv_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    output logic [DATA_W-1:0] mdu_operand1,
    output logic [DATA_W-1:0] mdu_operand2,
    input  logic [DATA_W-1:0] divu_quotient,
    input  logic [HALF_W-1:0] divu_remainder,
    input  logic [DATA_W-1:0] divs_quotient,
    input  logic [HALF_W-1:0] divs_remainder,
    input  logic [DATA_W-1:0] mulu_result,
    input  logic [DATA_W-1:0] muls_result,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_c,
    output logic              div_by_zero
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  lat_c;
    op_e               op_q;
    logic [DATA_W-1:0] hold_q;
    logic              dz_q;
    logic              div0_c;
    logic              load_c;
    logic              dz_load_c;
    logic              capture_c;
    logic              busy_d;
    logic [DATA_W-1:0] pack_result_c;
    flags_t            pack_flags_c;

    assign div0_c = op_is_div(op_e'(op)) && (operand2[HALF_W-1:0] == '0);
    assign lat_c  = op_is_div(op_e'(op)) ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and latency counter; FINISH accepts a new request like IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (div0_c) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control strobes for the datapath registers.
    always_comb begin
        load_c    = 1'b0;
        dz_load_c = 1'b0;
        capture_c = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            ST_WAIT: busy_d = 1'b1;
            ST_IDLE, ST_FINISH: begin
                capture_c = (state_q == ST_FINISH);
                if (start) begin
                    busy_d    = 1'b1;
                    load_c    = !div0_c;
                    dz_load_c = div0_c;
                end
            end
            default: ;
        endcase
    end

    muldiv_result_pack u_pack (
        .op             (op_q),
        .operand1       (mdu_operand1),
        .divu_quotient  (divu_quotient),
        .divu_remainder (divu_remainder),
        .divs_quotient  (divs_quotient),
        .divs_remainder (divs_remainder),
        .mulu_result    (mulu_result),
        .muls_result    (muls_result),
        .result_c       (pack_result_c),
        .flags_c        (pack_flags_c)
    );

    // Datapath registers: operand freeze, counter, result and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            op_q         <= OP_MULU;
            mdu_operand1 <= '0;
            mdu_operand2 <= '0;
            hold_q       <= '0;
            dz_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            result       <= '0;
            flag_n       <= 1'b0;
            flag_z       <= 1'b0;
            flag_v       <= 1'b0;
            flag_c       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= capture_c;
            div_by_zero <= capture_c && dz_q;
            if (load_c) begin
                op_q         <= op_e'(op);
                mdu_operand1 <= operand1;
                mdu_operand2 <= operand2;
                dz_q         <= 1'b0;
            end
            // Divide-by-zero keeps the unit operands untouched.
            if (dz_load_c) begin
                hold_q <= operand1;
                dz_q   <= 1'b1;
            end
            if (capture_c) begin
                if (dz_q) begin
                    result <= hold_q;
                    flag_n <= 1'b0;
                    flag_z <= 1'b0;
                    flag_v <= 1'b0;
                    flag_c <= 1'b0;
                end else begin
                    result <= pack_result_c;
                    flag_n <= pack_flags_c.n;
                    flag_z <= pack_flags_c.z;
                    flag_v <= pack_flags_c.v;
                    flag_c <= pack_flags_c.c;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench: pipelined unit model plus an arithmetic reference model.
module tb_alu_muldiv_sequencer;

    localparam int MUL_LAT = 18;
    localparam int DIV_LAT = 30;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand1, operand2;
    logic [31:0] mdu_operand1, mdu_operand2;
    logic [31:0] divu_quotient, divs_quotient, mulu_result, muls_result;
    logic [15:0] divu_remainder, divs_remainder;
    logic        busy, done, flag_n, flag_z, flag_v, flag_c, div_by_zero;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_mdu1 = '0;
    logic [31:0] exp_mdu2 = '0;

    always #5 clock = ~clock;

    alu_muldiv_sequencer #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT),
        .CNT_W       (6)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .op             (op),
        .operand1       (operand1),
        .operand2       (operand2),
        .mdu_operand1   (mdu_operand1),
        .mdu_operand2   (mdu_operand2),
        .divu_quotient  (divu_quotient),
        .divu_remainder (divu_remainder),
        .divs_quotient  (divs_quotient),
        .divs_remainder (divs_remainder),
        .mulu_result    (mulu_result),
        .muls_result    (muls_result),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .flag_n         (flag_n),
        .flag_z         (flag_z),
        .flag_v         (flag_v),
        .flag_c         (flag_c),
        .div_by_zero    (div_by_zero)
    );

    // Pipelined unit model: samples the operands every clock, fixed depth.
    logic [31:0] mulu_p [MUL_LAT];
    logic [31:0] muls_p [MUL_LAT];
    logic [31:0] divuq_p [DIV_LAT];
    logic [31:0] divsq_p [DIV_LAT];
    logic [15:0] divur_p [DIV_LAT];
    logic [15:0] divsr_p [DIV_LAT];

    always @(posedge clock) begin : unit_model
        longint sa, sd, q, r;
        for (int i = MUL_LAT - 1; i > 0; i--) begin
            mulu_p[i] <= mulu_p[i-1];
            muls_p[i] <= muls_p[i-1];
        end
        for (int i = DIV_LAT - 1; i > 0; i--) begin
            divuq_p[i] <= divuq_p[i-1];
            divsq_p[i] <= divsq_p[i-1];
            divur_p[i] <= divur_p[i-1];
            divsr_p[i] <= divsr_p[i-1];
        end
        sa = longint'({48'd0, mdu_operand1[15:0]});
        sd = longint'({48'd0, mdu_operand2[15:0]});
        q  = sa * sd;
        mulu_p[0] <= q[31:0];
        sa = $signed(mdu_operand1[15:0]);
        sd = $signed(mdu_operand2[15:0]);
        q  = sa * sd;
        muls_p[0] <= q[31:0];
        if (mdu_operand2[15:0] == 16'd0) begin
            divuq_p[0] <= '0; divur_p[0] <= '0; divsq_p[0] <= '0; divsr_p[0] <= '0;
        end else begin
            sa = longint'({32'd0, mdu_operand1});
            sd = longint'({48'd0, mdu_operand2[15:0]});
            q  = sa / sd;
            r  = sa % sd;
            divuq_p[0] <= q[31:0];
            divur_p[0] <= r[15:0];
            sa = $signed(mdu_operand1);
            sd = $signed(mdu_operand2[15:0]);
            q  = sa / sd;
            r  = sa - q * sd;
            divsq_p[0] <= q[31:0];
            divsr_p[0] <= r[15:0];
        end
    end

    assign mulu_result    = mulu_p[MUL_LAT-1];
    assign muls_result    = muls_p[MUL_LAT-1];
    assign divu_quotient  = divuq_p[DIV_LAT-1];
    assign divu_remainder = divur_p[DIV_LAT-1];
    assign divs_quotient  = divsq_p[DIV_LAT-1];
    assign divs_remainder = divsr_p[DIV_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 68000 MUL/DIV semantics in plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f,
                                      output logic dz, output int lat);
        longint sa, sd, q, rm;
        bit ovf;
        r = '0; f = '0; dz = 1'b0; ovf = 1'b0; q = 0; rm = 0;
        lat = o[1] ? DIV_LAT + 2 : MUL_LAT + 2;
        if (o < 2) begin
            if (o == 2'd0) begin
                sa = longint'({48'd0, a[15:0]});
                sd = longint'({48'd0, b[15:0]});
            end else begin
                sa = $signed(a[15:0]);
                sd = $signed(b[15:0]);
            end
            q = sa * sd;
            r = q[31:0];
            f = {r[31], r == 32'd0, 2'b00};
        end else if (b[15:0] == 16'd0) begin
            dz = 1'b1; r = a; lat = 2;
        end else begin
            if (o == 2'd2) begin
                sa = longint'({32'd0, a});
                sd = longint'({48'd0, b[15:0]});
                q = sa / sd;
                ovf = q > 65535;
            end else begin
                sa = $signed(a);
                sd = $signed(b[15:0]);
                q = sa / sd;
                ovf = (q > 32767) || (q < -32768);
            end
            rm = sa - q * sd;
            if (ovf) begin
                r = a; f = 4'b0010;
            end else begin
                r = {rm[15:0], q[15:0]};
                f = {q[15], q[15:0] == 16'd0, 2'b00};
            end
        end
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; operand1 = a; operand2 = b; start = 1'b1;
    endtask

    task automatic scramble();
        op = 2'($urandom); operand1 = $urandom; operand2 = $urandom;
    endtask

    // Collect one operation; optionally hammer start or chain the next request in FINISH.
    task automatic wait_done(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input bit skip_first, input bit hammer, input bit chain,
                             input logic [1:0] nop, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] er;
        logic [3:0]  ef;
        logic        edz;
        int          lat, cyc, busy_cnt;
        ref_model(o, a, b, er, ef, edz, lat);
        if (!edz) begin exp_mdu1 = a; exp_mdu2 = b; end
        if (!skip_first) @(negedge clock);
        start = 1'b0;
        scramble();
        check("mdu_operand1", mdu_operand1, exp_mdu1);
        check("mdu_operand2", mdu_operand2, exp_mdu2);
        cyc = -1; busy_cnt = 0;
        for (int k = 1; k <= lat + 8; k++) begin
            if (k > 1 && done) begin cyc = k; break; end
            if (busy) busy_cnt++;
            if (hammer && k < lat - 1) begin
                start = 1'b1; scramble();
            end else if (chain && k == lat - 1) begin
                issue(nop, na, nb);
            end else begin
                start = 1'b0; scramble();
            end
            @(negedge clock);
        end
        check("latency", 64'(cyc), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
        check("result", result, er);
        check("flags_nzvc", {flag_n, flag_z, flag_v, flag_c}, ef);
        check("div_by_zero", div_by_zero, edz);
        if (!chain) begin
            check("busy_at_done", busy, 1'b0);
            start = 1'b0;
            @(negedge clock);
            check("done_pulse", done, 1'b0);
            check("dbz_pulse", div_by_zero, 1'b0);
            check("result_hold", result, er);
            check("mdu_hold", mdu_operand1, exp_mdu1);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        wait_done(o, a, b, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_flags"}, {flag_n, flag_z, flag_v, flag_c}, 4'd0);
        check({tag, "_dbz"}, div_by_zero, 1'b0);
        check({tag, "_mdu1"}, mdu_operand1, 32'd0);
        check({tag, "_mdu2"}, mdu_operand2, 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;
        reset_n = 1'b0; start = 1'b0; op = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        run(2'd0, 32'h0000FFFF, 32'h0000FFFF);
        run(2'd1, 32'h0000FFFF, 32'h00000002);
        run(2'd1, 32'h00000000, 32'h00001234);
        run(2'd2, 32'h000186A0, 32'h00000007);
        run(2'd3, 32'hFFFFFFF9, 32'h00000002);
        run(2'd2, 32'h00100000, 32'h00000001);
        run(2'd3, 32'h80000000, 32'h0000FFFF);
        run(2'd3, 32'h00010000, 32'h00000002);
        run(2'd2, 32'hCAFEF00D, 32'h00000000);
        run(2'd3, 32'h12345678, 32'hABCD0000);

        // start held high throughout a divide
        issue(2'd2, 32'h000186A0, 32'h00000007);
        wait_done(2'd2, 32'h000186A0, 32'h00000007, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);

        // back-to-back request in the FINISH cycle
        issue(2'd0, 32'h00001234, 32'h00005678);
        wait_done(2'd0, 32'h00001234, 32'h00005678, 1'b0, 1'b0, 1'b1, 2'd3, 32'hFFFFFFF9, 32'h00000002);
        wait_done(2'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        // reset in the middle of a divide
        issue(2'd2, 32'h12345678, 32'h00000123);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #2;
        check_all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        exp_mdu1 = '0; exp_mdu2 = '0;
        seen = 1'b0;
        for (int k = 0; k < DIV_LAT + 5; k++) begin
            @(negedge clock);
            seen = seen | done;
        end
        check("no_done_after_reset", seen, 1'b0);
        run(2'd0, 32'h0000ABCD, 32'h00001234);

        // randomized operations
        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb[15:0] = 16'd0;
                1: rb[15:0] = 16'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) ra[31:16] = ra[15] ? 16'hFFFF : 16'h0000;
            run(ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
